mul_accumulator: RTL and testbench



---
 rtl/mul_accumulator_if.sv | 24 ++
 rtl/mul_accumulator.sv | 105 ++++++++++
 tb/tb_mul_accumulator.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_accumulator_if.sv
// Handshake bundle between the product source, the accumulator and the sum consumer.
// master drives products and consumes sums; slave is the accumulator itself.
interface mul_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10
);
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_data;
  logic              acc_ovf;

  modport master (
    output prod_valid, prod_data, acc_ready,
    input  prod_ready, acc_valid, acc_data, acc_ovf
  );

  modport slave (
    input  prod_valid, prod_data, acc_ready,
    output prod_ready, acc_valid, acc_data, acc_ovf
  );
endinterface

// File: rtl/mul_accumulator.sv
// Frame accumulator: sums N_TERMS unsigned products and presents the sum plus a sticky carry flag.
// Define MUL_ACC_BACK2BACK_EN to let a new frame start in the same cycle the previous sum leaves.
module mul_accumulator #(
  parameter int PROD_W  = 8,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input logic               clk,
  input logic               rst,
  mul_accumulator_if.slave  bus
);
  localparam int CNT_W = ($clog2(N_TERMS + 1) < 1) ? 1 : $clog2(N_TERMS + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             prod_ready_int;
  logic             acc_valid_int;

  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum_wide;
  logic             last_term;

  // The extra top bit of the sum is the carry-out that feeds the sticky flag.
  assign prod_ext  = {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_data};
  assign sum_wide  = {1'b0, acc_reg} + prod_ext;
  assign last_term = (cnt_reg == CNT_W'(N_TERMS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    ovf_next       = ovf_reg;
    cnt_next       = cnt_reg;
    prod_ready_int = 1'b0;
    acc_valid_int  = 1'b0;
    case (state_reg)
      ACCUM: begin
        prod_ready_int = 1'b1;
        if (bus.prod_valid) begin
          acc_next = sum_wide[ACC_W-1:0];
          ovf_next = ovf_reg | sum_wide[ACC_W];
          if (last_term) begin
            cnt_next   = '0;
            state_next = HOLD;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        acc_valid_int = 1'b1;
`ifdef MUL_ACC_BACK2BACK_EN
        prod_ready_int = bus.acc_ready;
        if (bus.acc_ready) begin
          if (bus.prod_valid) begin
            // First product of the next frame replaces the sum being handed off.
            acc_next = prod_ext[ACC_W-1:0];
            ovf_next = 1'b0;
            if (N_TERMS == 1) begin
              cnt_next   = '0;
              state_next = HOLD;
            end else begin
              cnt_next   = CNT_W'(1);
              state_next = ACCUM;
            end
          end else begin
            acc_next   = '0;
            ovf_next   = 1'b0;
            state_next = ACCUM;
          end
        end
`else
        if (bus.acc_ready) begin
          acc_next   = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
`endif
      end
      default: state_next = ACCUM;
    endcase
  end

  assign bus.prod_ready = prod_ready_int;
  assign bus.acc_valid  = acc_valid_int;
  assign bus.acc_data   = acc_reg;
  assign bus.acc_ovf    = ovf_reg;
endmodule

// File: tb/tb_mul_accumulator.sv
// Scoreboard bench for mul_accumulator: default, 9-bit accumulator and single-term instances.
module tb_mul_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_accumulator_if #(.PROD_W(8), .ACC_W(10)) bus0 ();
  mul_accumulator_if #(.PROD_W(8), .ACC_W(9))  bus9 ();
  mul_accumulator_if #(.PROD_W(8), .ACC_W(10)) bus1 ();

  mul_accumulator #(.PROD_W(8), .N_TERMS(4), .ACC_W(10)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mul_accumulator #(.PROD_W(8), .N_TERMS(4), .ACC_W(9))  u_dut9 (.clk(clk), .rst(rst), .bus(bus9));
  mul_accumulator #(.PROD_W(8), .N_TERMS(1), .ACC_W(10)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {int edge_no; int data; bit ovf;} obs_t;
  typedef struct {int data; bit ovf;} exp_t;

  obs_t obs0[$], obs9[$], obs1[$];
  exp_t exp0[$], exp9[$], exp1[$];
  int   in_edges0[$], in_edges1[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Transfers seen at a falling edge complete on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.acc_valid && bus0.acc_ready) obs0.push_back('{edge_cnt + 1, int'(bus0.acc_data), bus0.acc_ovf});
      if (bus9.acc_valid && bus9.acc_ready) obs9.push_back('{edge_cnt + 1, int'(bus9.acc_data), bus9.acc_ovf});
      if (bus1.acc_valid && bus1.acc_ready) obs1.push_back('{edge_cnt + 1, int'(bus1.acc_data), bus1.acc_ovf});
      if (bus0.prod_valid && bus0.prod_ready) in_edges0.push_back(edge_cnt + 1);
      if (bus1.prod_valid && bus1.prod_ready) in_edges1.push_back(edge_cnt + 1);
    end
  end

  task automatic set_in(input int sel, input logic v, input int d);
    case (sel)
      0: begin bus0.prod_valid = v; bus0.prod_data = d[7:0]; end
      1: begin bus9.prod_valid = v; bus9.prod_data = d[7:0]; end
      default: begin bus1.prod_valid = v; bus1.prod_data = d[7:0]; end
    endcase
  endtask

  task automatic set_ack(input int sel, input logic r);
    case (sel)
      0: bus0.acc_ready = r;
      1: bus9.acc_ready = r;
      default: bus1.acc_ready = r;
    endcase
  endtask

  function automatic logic get_ready(input int sel);
    case (sel)
      0: return bus0.prod_ready;
      1: return bus9.prod_ready;
      default: return bus1.prod_ready;
    endcase
  endfunction

  function automatic int obs_size(input int sel);
    case (sel)
      0: return obs0.size();
      1: return obs9.size();
      default: return obs1.size();
    endcase
  endfunction

  // Presents each value until it is accepted, then idles for gap cycles.
  task automatic drive(input int sel, input int vals[$], input int gap);
    logic rdy;
    int   tmo;
    foreach (vals[i]) begin
      set_in(sel, 1'b1, vals[i]);
      tmo = 0;
      while (1) begin
        @(negedge clk);
        rdy = get_ready(sel);
        @(posedge clk); #1;
        if (rdy) break;
        tmo++;
        if (tmo > 100) begin
          n_checks++;
          $display("FAIL drive_timeout dut=%0d value=%0d: prod_ready never seen, required within 100 cycles", sel, vals[i]);
          break;
        end
      end
      set_in(sel, 1'b0, 0);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_obs(input int sel, input int n);
    int k = 0;
    while (obs_size(sel) < n && k < 100) begin @(posedge clk); #1; k++; end
    if (obs_size(sel) < n) begin
      n_checks++;
      $display("FAIL wait_sum dut=%0d: got %0d sums, required %0d", sel, obs_size(sel), n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 1'b0, 0); set_in(1, 1'b0, 0); set_in(2, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    obs0.delete(); obs9.delete(); obs1.delete();
    exp0.delete(); exp9.delete(); exp1.delete();
    in_edges0.delete(); in_edges1.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 1'b0, 0); set_in(1, 1'b0, 0); set_in(2, 1'b0, 0);
    set_ack(0, 1'b0); set_ack(1, 1'b0); set_ack(2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus0.acc_valid !== 1'b0) $display("FAIL reset_acc_valid: got %b, required 0", bus0.acc_valid); else n_pass++;
    n_checks++; if (bus0.prod_ready !== 1'b1) $display("FAIL reset_prod_ready: got %b, required 1", bus0.prod_ready); else n_pass++;
    n_checks++; if (bus0.acc_data !== 10'd0) $display("FAIL reset_acc_data: got %0d, required 0", bus0.acc_data); else n_pass++;
    n_checks++; if (bus0.acc_ovf !== 1'b0) $display("FAIL reset_acc_ovf: got %b, required 0", bus0.acc_ovf); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus1.prod_ready !== 1'b1) $display("FAIL reset_prod_ready_n1: got %b, required 1", bus1.prod_ready); else n_pass++;
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    int   v[$];
    obs_t o;
    exp_t e;
    do_reset();
    set_ack(0, 1'b1);
    exp0.push_back('{900, 1'b0});
    v = {225, 225, 225, 225};
    drive(0, v, 0);
    @(negedge clk);
    n_checks++; if (bus0.acc_valid !== 1'b1) $display("FAIL basic_valid_rise: got %b, required 1", bus0.acc_valid); else n_pass++;
    n_checks++; if (bus0.acc_data !== 10'd900) $display("FAIL basic_data_at_valid: got %0d, required 900", bus0.acc_data); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (bus0.acc_valid !== 1'b0) $display("FAIL basic_valid_fall: got %b, required 0", bus0.acc_valid); else n_pass++;
    wait_obs(0, 1);
    while (obs0.size() > 0 && exp0.size() > 0) begin
      o = obs0.pop_front(); e = exp0.pop_front();
      n_checks++; if (o.data !== e.data) $display("FAIL basic_sum: got %0d, required %0d", o.data, e.data); else n_pass++;
      n_checks++; if (o.ovf !== e.ovf) $display("FAIL basic_ovf: got %b, required %b", o.ovf, e.ovf); else n_pass++;
      $display("basic: sum=%0d ovf=%b", o.data, o.ovf);
    end
  endtask

  task automatic test_overflow();
    int   v[$];
    obs_t o;
    exp_t e;
    do_reset();
    set_ack(1, 1'b1);
    exp9.push_back('{900 % 512, 1'b1});
    exp9.push_back('{10, 1'b0});
    v = {225, 225, 225, 225, 1, 2, 3, 4};
    drive(1, v, 0);
    wait_obs(1, 2);
    while (obs9.size() > 0 && exp9.size() > 0) begin
      o = obs9.pop_front(); e = exp9.pop_front();
      n_checks++; if (o.data !== e.data) $display("FAIL ovf_sum: got %0d, required %0d", o.data, e.data); else n_pass++;
      n_checks++; if (o.ovf !== e.ovf) $display("FAIL ovf_flag: got %b, required %b", o.ovf, e.ovf); else n_pass++;
      $display("overflow: sum=%0d ovf=%b", o.data, o.ovf);
    end
  endtask

  task automatic test_backpressure();
    int   v[$];
    int   rel;
    obs_t o;
    exp_t e;
    do_reset();
    set_ack(0, 1'b0);
    exp0.push_back('{19, 1'b0});
    v = {6, 0, 9, 4};
    drive(0, v, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (bus0.acc_valid !== 1'b1) $display("FAIL bp_valid c=%0d: got %b, required 1", c, bus0.acc_valid); else n_pass++;
      n_checks++; if (bus0.acc_data !== 10'd19) $display("FAIL bp_data c=%0d: got %0d, required 19", c, bus0.acc_data); else n_pass++;
      n_checks++; if (bus0.prod_ready !== 1'b0) $display("FAIL bp_prod_ready c=%0d: got %b, required 0", c, bus0.prod_ready); else n_pass++;
      @(posedge clk); #1;
    end
    set_ack(0, 1'b1);
    rel = edge_cnt + 1;
    wait_obs(0, 1);
    while (obs0.size() > 0 && exp0.size() > 0) begin
      o = obs0.pop_front(); e = exp0.pop_front();
      n_checks++; if (o.data !== e.data) $display("FAIL bp_sum: got %0d, required %0d", o.data, e.data); else n_pass++;
      n_checks++; if (o.edge_no !== rel) $display("FAIL bp_release_edge: got %0d, required %0d", o.edge_no, rel); else n_pass++;
      $display("backpressure: sum=%0d released at edge %0d", o.data, o.edge_no);
    end
  endtask

  task automatic test_gapped();
    int   v[$];
    obs_t o;
    exp_t e;
    do_reset();
    set_ack(0, 1'b1);
    exp0.push_back('{32, 1'b0});
    v = {8, 8, 8, 8};
    drive(0, v, 2);
    wait_obs(0, 1);
    n_checks++; if (in_edges0.size() !== 4) $display("FAIL gap_transfers: got %0d, required 4", in_edges0.size()); else n_pass++;
    while (obs0.size() > 0 && exp0.size() > 0) begin
      o = obs0.pop_front(); e = exp0.pop_front();
      n_checks++; if (o.data !== e.data) $display("FAIL gap_sum: got %0d, required %0d", o.data, e.data); else n_pass++;
      $display("gapped: sum=%0d transfers=%0d", o.data, in_edges0.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int   v[$];
    obs_t o;
    exp_t e;
    do_reset();
    set_ack(0, 1'b1);
    v = {100, 100};
    drive(0, v, 0);
    @(negedge clk);
    n_checks++; if (bus0.acc_data !== 10'd200) $display("FAIL mid_partial: got %0d, required 200", bus0.acc_data); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus0.acc_data !== 10'd0) $display("FAIL mid_async_clear: got %0d, required 0", bus0.acc_data); else n_pass++;
    n_checks++; if (bus0.acc_valid !== 1'b0) $display("FAIL mid_valid: got %b, required 0", bus0.acc_valid); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp0.push_back('{4, 1'b0});
    v = {1, 1, 1, 1};
    drive(0, v, 0);
    wait_obs(0, 1);
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (obs0.size() !== 1) $display("FAIL mid_sum_count: got %0d, required 1", obs0.size()); else n_pass++;
    while (obs0.size() > 0 && exp0.size() > 0) begin
      o = obs0.pop_front(); e = exp0.pop_front();
      n_checks++; if (o.data !== e.data) $display("FAIL mid_sum: got %0d, required %0d", o.data, e.data); else n_pass++;
      $display("reset_mid_frame: sum=%0d", o.data);
    end
  endtask

  task automatic test_back_to_back();
    int   v[$];
    int   offs[$];
    int   first;
    int   k;
    obs_t o;
    exp_t e;
    do_reset();
    set_ack(0, 1'b1);
`ifdef MUL_ACC_BACK2BACK_EN
    offs = {4, 8, 12};
`else
    offs = {4, 9, 14};
`endif
    for (int i = 0; i < 12; i++) v.push_back(2);
    for (int i = 0; i < 3; i++) exp0.push_back('{8, 1'b0});
    drive(0, v, 0);
    wait_obs(0, 3);
    first = (in_edges0.size() > 0) ? in_edges0[0] : 0;
    k = 0;
    while (obs0.size() > 0 && exp0.size() > 0 && k < 3) begin
      o = obs0.pop_front(); e = exp0.pop_front();
      n_checks++; if (o.data !== e.data) $display("FAIL b2b_sum%0d: got %0d, required %0d", k, o.data, e.data); else n_pass++;
      n_checks++; if (o.edge_no - first !== offs[k]) $display("FAIL b2b_cycle%0d: got %0d, required %0d", k, o.edge_no - first, offs[k]); else n_pass++;
      $display("back_to_back: sum=%0d at cycle %0d", o.data, o.edge_no - first);
      k++;
    end
  endtask

  task automatic test_single_term();
    int   v[$];
    int   offs[$];
    int   first;
    int   k;
    obs_t o;
    exp_t e;
    do_reset();
    set_ack(2, 1'b1);
`ifdef MUL_ACC_BACK2BACK_EN
    offs = {1, 2, 3};
`else
    offs = {1, 3, 5};
`endif
    v = {5, 7, 255};
    foreach (v[i]) exp1.push_back('{v[i], 1'b0});
    drive(2, v, 0);
    wait_obs(2, 3);
    first = (in_edges1.size() > 0) ? in_edges1[0] : 0;
    k = 0;
    while (obs1.size() > 0 && exp1.size() > 0 && k < 3) begin
      o = obs1.pop_front(); e = exp1.pop_front();
      n_checks++; if (o.data !== e.data) $display("FAIL n1_sum%0d: got %0d, required %0d", k, o.data, e.data); else n_pass++;
      n_checks++; if (o.edge_no - first !== offs[k]) $display("FAIL n1_cycle%0d: got %0d, required %0d", k, o.edge_no - first, offs[k]); else n_pass++;
      $display("single_term: sum=%0d at cycle %0d", o.data, o.edge_no - first);
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_gapped();
    test_reset_mid_frame();
    test_back_to_back();
    test_single_term();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
